// File: rtl/if_fetch_unit.sv
// if_fetch_unit: owns the PC, fetches from imem, fills the IF/ID slot.
// Optional feature macro: MISALIGN_TRAP_EN (adds fetch_misaligned).
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid,
`ifdef MISALIGN_TRAP_EN
    output logic        fetch_misaligned,
`endif
    output logic        flush
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    logic        kill;
    logic        consume;
    logic        slot_free;
    logic        outstanding;
    logic        misaligned;
    logic        park;
    logic [31:0] target;

    assign consume   = if_valid & ~stall;
    assign slot_free = ~if_valid | consume;
    assign flush     = redirect;
    assign imem_req  = (state_q == REQ);
    assign imem_addr = pc_q;

    // A response still owed by memory unless it lands this very cycle.
    // IDLE+kill covers a request abandoned by a misaligned redirect.
    assign outstanding =
        (((state_q == WAIT) | ((state_q == IDLE) & kill)) & ~imem_rvalid)
        | ((state_q == REQ) & imem_gnt);

`ifdef MISALIGN_TRAP_EN
    assign target     = redirect_pc;
    assign misaligned = |redirect_pc[1:0];
    assign park       = fetch_misaligned;

    // Sticky trap flag, updated by every redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_misaligned <= 1'b0;
        end else if (redirect) begin
            fetch_misaligned <= misaligned;
        end
    end
`else
    assign target     = redirect_pc & 32'hFFFF_FFFC;
    assign misaligned = 1'b0;
    assign park       = 1'b0;
`endif

    // Fetch FSM, PC, output slot and hold buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            kill       <= 1'b0;
            if_valid   <= 1'b0;
            if_pc      <= 32'h0;
            if_instr   <= 32'h0;
            hold_pc    <= 32'h0;
            hold_instr <= 32'h0;
        end else if (redirect) begin
            if_valid   <= 1'b0;
            hold_pc    <= 32'h0;
            hold_instr <= 32'h0;
            pc_q       <= target;
            kill       <= outstanding;
            if (misaligned) begin
                state_q <= IDLE;
            end else if (outstanding) begin
                state_q <= WAIT;
            end else begin
                state_q <= REQ;
            end
        end else begin
            if (consume) begin
                if_valid <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (kill) begin
                        if (imem_rvalid) begin
                            kill <= 1'b0;
                        end
                    end else if (!park) begin
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (imem_gnt) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid && kill) begin
                        kill    <= 1'b0;
                        state_q <= REQ;
                    end else if (imem_rvalid) begin
                        pc_q <= pc_q + 32'd4;
                        if (slot_free) begin
                            if_pc    <= pc_q;
                            if_instr <= imem_rdata;
                            if_valid <= 1'b1;
                            state_q  <= REQ;
                        end else begin
                            hold_pc    <= pc_q;
                            hold_instr <= imem_rdata;
                            state_q    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        if_pc    <= hold_pc;
                        if_instr <= hold_instr;
                        if_valid <= 1'b1;
                        state_q  <= REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: random memory/stall/redirect stimulus,
// program-order scoreboard of expected fetched PCs.
`timescale 1ns/1ps
module tb_if_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        flush;
`ifdef MISALIGN_TRAP_EN
    logic        fetch_misaligned;
`endif

    int          checks = 0;
    int          errors = 0;
    int          ndeliv = 0;
    logic [31:0] exp_q[$];
    logic [31:0] tail;
    bit          seq_on = 0;

    int          lat_mode = 0;
    bit          pend = 0;
    int          cnt = 0;
    logic [31:0] paddr = 32'h0;

    if_fetch_unit #(.RESET_PC(RPC)) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .if_pc(if_pc),
        .if_instr(if_instr),
        .if_valid(if_valid),
`ifdef MISALIGN_TRAP_EN
        .fetch_misaligned(fetch_misaligned),
`endif
        .flush(flush)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a fixed function of the address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic void top_up();
        if (seq_on) begin
            while (exp_q.size() < 16) begin
                tail = tail + 32'd4;
                exp_q.push_back(tail);
            end
        end
    endfunction

    // Program order restarts at start (mod 2^32 sequential PCs).
    function automatic void push_seq(input logic [31:0] start);
        exp_q.delete();
        tail   = start;
        exp_q.push_back(start);
        seq_on = 1;
        top_up();
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
        top_up();
    endtask

    // Memory model: grants, then answers after cnt idle cycles.
    always begin
        @(posedge clk);
        #1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (rst) begin
            pend = 0;
        end else if (pend) begin
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem(paddr);
                pend        = 0;
            end else begin
                cnt--;
            end
        end else if (imem_req &&
                     (lat_mode != 2 || $urandom_range(0, 2) != 0)) begin
            imem_gnt = 1'b1;
            paddr    = imem_addr;
            pend     = 1;
            if (lat_mode == 0) cnt = 0;
            else if (lat_mode == 1) cnt = 2;
            else cnt = $urandom_range(0, 3);
        end
    end

    logic        ph_v = 0;
    logic [31:0] ph_pc;
    logic [31:0] ph_in;
    logic        pr_v = 0;
    logic [31:0] pr_addr;
    logic [31:0] mon_e;

    // Monitor: pops the scoreboard on every consumed slot.
    always @(negedge clk) begin
        if (rst) begin
            ph_v = 0;
            pr_v = 0;
        end else begin
            chk("flush", {31'h0, flush}, {31'h0, redirect});
            if (ph_v) begin
                chk("stall_valid", {31'h0, if_valid}, 32'h1);
                chk("stall_pc", if_pc, ph_pc);
                chk("stall_instr", if_instr, ph_in);
            end
            if (pr_v) begin
                chk("req_held", {31'h0, imem_req}, 32'h1);
                chk("addr_stable", imem_addr, pr_addr);
            end
            if (if_valid && !stall && !redirect) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_delivery actual=%h required=none",
                             if_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pc", if_pc, mon_e);
                    chk("instr", if_instr, mem(mon_e));
                end
                ndeliv++;
            end
            ph_v    = if_valid && stall && !redirect;
            ph_pc   = if_pc;
            ph_in   = if_instr;
            pr_v    = imem_req && !imem_gnt && !redirect;
            pr_addr = imem_addr;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic wait_req(input string name, input logic [31:0] addr);
        bit found = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin
                found = 1;
                break;
            end
            tick();
        end
        chk({name, "_seen"}, {31'h0, found}, 32'h1);
        if (found) chk(name, imem_addr, addr);
    endtask

    initial begin
        int base;
        bit found;
        logic [31:0] t;

        repeat (3) tick();
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, RPC);
`ifdef MISALIGN_TRAP_EN
        chk("rst_mis", {31'h0, fetch_misaligned}, 32'h0);
`endif

        // 1: reset release, 1-cycle memory, no stall
        lat_mode = 0;
        push_seq(RPC);
        rst = 1'b0;
        base = ndeliv;
        repeat (12) tick();
        chk("t1_rate", ndeliv - base, 32'd5);

        // 2: stall with slot full while a response arrives
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (if_valid) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("t2_full", {31'h0, found}, 32'h1);
        stall = 1'b1;
        repeat (3) tick();
        stall = 1'b0;
        base = ndeliv;
        repeat (10) tick();
        chk("t2_resume", {31'h0, (ndeliv - base) >= 3}, 32'h1);

        // 3: redirect while a request is in WAIT
        lat_mode = 1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (pend && cnt == 1) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("t3_wait", {31'h0, found}, 32'h1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        push_seq(32'h0000_0100);
        #1;
        chk("t3_flush", {31'h0, flush}, 32'h1);
        tick();
        redirect = 1'b0;
        wait_req("t3_addr", 32'h0000_0100);
        base = ndeliv;
        repeat (20) tick();
        chk("t3_deliv", {31'h0, (ndeliv - base) >= 2}, 32'h1);

        // 4: PC wrap at the top of the address space
        lat_mode    = 0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        push_seq(32'hFFFF_FFF8);
        tick();
        redirect = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req && imem_addr == 32'h0) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("t4_wrap_addr", {31'h0, found}, 32'h1);
        repeat (6) tick();

        // 5: reset while in WAIT with the slot full
        lat_mode = 1;
        stall    = 1'b1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (if_valid && pend) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("t5_setup", {31'h0, found}, 32'h1);
        rst = 1'b1;
        exp_q.delete();
        seq_on = 0;
        #1;
        chk("t5_valid", {31'h0, if_valid}, 32'h0);
        chk("t5_pc", if_pc, 32'h0);
        chk("t5_instr", if_instr, 32'h0);
        chk("t5_req", {31'h0, imem_req}, 32'h0);
        repeat (2) tick();
        stall = 1'b0;
        push_seq(RPC);
        rst = 1'b0;
        wait_req("t5_addr", RPC);
        repeat (10) tick();

        // 6: misaligned redirect target
        lat_mode = 0;
`ifdef MISALIGN_TRAP_EN
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        exp_q.delete();
        seq_on = 0;
        tick();
        redirect = 1'b0;
        chk("t6_mis_set", {31'h0, fetch_misaligned}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            chk("t6_noreq", {31'h0, imem_req}, 32'h0);
            tick();
        end
        chk("t6_mis_hold", {31'h0, fetch_misaligned}, 32'h1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        push_seq(32'h0000_0200);
        tick();
        redirect = 1'b0;
        chk("t6_mis_clr", {31'h0, fetch_misaligned}, 32'h0);
        wait_req("t6_addr", 32'h0000_0200);
`else
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        push_seq(32'h0000_0100);
        tick();
        redirect = 1'b0;
        wait_req("t6_addr", 32'h0000_0100);
`endif
        repeat (10) tick();

        // Random traffic against the scoreboard
        lat_mode = 2;
        base = ndeliv;
        for (int i = 0; i < 2500; i++) begin
            stall = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 39) == 0) begin
                t = $urandom;
                if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0;
                t = t & 32'hFFFF_FFFC;
                redirect    = 1'b1;
                redirect_pc = t;
                push_seq(t);
            end else begin
                redirect = 1'b0;
            end
            tick();
        end
        redirect = 1'b0;
        stall    = 1'b0;
        repeat (10) tick();
        chk("rand_progress", {31'h0, (ndeliv - base) > 100}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
